multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB over a stalling MMIO bus
//  (req/ready handshake), drives per-state datapath strobes and holds a LL/SC reservation.
//  Has a bus-timeout trap. Sits between the instruction register and the datapath/MMIO bus.
// PARAMETERS
//  ADDR_W       32  width of the memory address used for the LL/SC reservation compare
//  MEM_TIMEOUT  16  cycles mem_ready may stay low in FETCH/MEM before trapping (>=2)
//  LLSC_EN      1   1: LL/SC reservation active; 0: SC always succeeds, no reservation kept
// PORTS
//  clk_in          in   1       clock, rising edge
//  rst_in          in   1       asynchronous, active-high reset
//  instruction_in  in   32      IR contents; valid from DECODE onward
//  alu_zero_in     in   1       ALU zero flag, sampled in EXEC
//  mem_addr_in     in   ADDR_W  effective address, valid in MEM
//  mem_ready_in    in   1       bus completes the current request this cycle
//  snoop_wr_in     in   1       another master wrote memory this cycle
//  snoop_addr_in   in   ADDR_W  address of that write
//  state_out       out  3       current FSM state encoding (debug)
//  ir_write        out  1       latch instruction (FETCH completion)
//  pc_write        out  1       load PC (PC+4 on fetch, target on taken branch/jump/jr)
//  pc_src          out  2       00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
//  mem_req         out  1       bus request, held until mem_ready_in
//  mem_we          out  1       store qualifier for mem_req
//  mMask           out  2       00 byte, 01 half, 10 word
//  reg_write       out  1       register-file write strobe (WB only)
//  reg_dst, alu_src, mem_to_reg, jal, lui, zero_ext  out 1 each  registered decode fields
//  sc_success      out  1       SC outcome written to rt in WB
//  bus_error       out  1       sticky timeout trap
//  instr_retired   out  1       one-cycle pulse on an instruction's final cycle
// BEHAVIOUR
//  Reset: state=FETCH, all outputs 0, reservation invalid, timeout counter 0.
//  FETCH: mem_req=1, mem_we=0, mMask=10. On mem_ready_in: ir_write=1, pc_write=1 (pc_src=00)
//   -> DECODE.
//  DECODE: 1 cycle; decode fields registered from instruction_in, stable until the next DECODE.
//   -> EXEC.
//  EXEC: BEQ/BNE: pc_write=(alu_zero_in==beq), pc_src=01. J/JAL: pc_write=1, pc_src=10.
//   JR: pc_write=1, pc_src=11. Branches/J/JR -> FETCH with retire. JAL -> WB. Loads/stores/LL/SC
//   -> MEM. Other known ops -> WB. Unknown opcode/funct: NOP, -> FETCH with retire.
//  MEM: mem_req=1, mem_we=store. On ready: load/LL -> WB; SB/SH/SW -> FETCH with retire;
//   SC -> WB. SC with LLSC_EN=1 and no valid matching reservation: no mem_req, sc_success=0,
//   -> WB next cycle.
//  WB: reg_write=1 for exactly one cycle, retire, -> FETCH.
//  Latency: ALU op 4 cycles, load 5, store 4, branch 3, each plus bus wait cycles.
//  Timeout: counter counts cycles with mem_req=1 and mem_ready_in=0 and clears on ready. At
//   MEM_TIMEOUT -> ERROR: all strobes 0, bus_error=1, remains in ERROR until rst_in.
//  Reservation (word granularity, addr[ADDR_W-1:2]):
//   - set on LL completion;
//   - cleared by any SC leaving MEM, by a snoop write to the same word, and by reset;
//   - a snoop write in the same cycle as LL completion: the set wins.
//  mem_ready_in outside FETCH/MEM is ignored.
//  Async reset mid-transfer drops mem_req immediately; no retire pulse.
// STRUCTURE
//  Package mmio_cpu_pkg: state_t enum {FETCH,DECODE,EXEC,MEM,WB,ERROR}, opcode/funct localparams,
//   mMask constants.
//  Sub-module llsc_reservation: valid bit plus address register, set/clear/match logic;
//   tied off when LLSC_EN=0.
// TESTING
//  ADDIU, mem_ready_in=1 immediately -> FETCH,DECODE,EXEC,WB; reg_write high in cycle 4 only;
//   one instr_retired pulse.
//  LW, ready delayed 3 cycles in MEM -> mem_req held 4 cycles in MEM; mMask=10; reg_write after.
//  BEQ, alu_zero_in=1 -> pc_write=1, pc_src=01 in EXEC; with alu_zero_in=0 -> pc_write=0 in EXEC.
//  LL 0x100, then SC 0x100 -> sc_success=1; LL 0x100, snoop write 0x102, SC -> sc_success=0,
//   no mem_req issued.
//  mem_ready_in held 0 in FETCH, MEM_TIMEOUT=16 -> ERROR after 16 cycles, bus_error=1 until reset.
//  Assert rst_in mid-MEM -> mem_req=0 asynchronously; restart fetch after release.

Source files
------------

// File: rtl/mmio_cpu_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, instruction classes, decode helper.
// Latency: n/a (types and a pure combinational decode function).
// Backpressure: n/a.
package mmio_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP   = 4'd0,
    CL_ALU   = 4'd1,
    CL_BEQ   = 4'd2,
    CL_BNE   = 4'd3,
    CL_J     = 4'd4,
    CL_JAL   = 4'd5,
    CL_JR    = 4'd6,
    CL_LOAD  = 4'd7,
    CL_STORE = 4'd8,
    CL_LL    = 4'd9,
    CL_SC    = 4'd10
  } iclass_t;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LB    = 6'h20, OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23, OP_LBU   = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30, OP_SC    = 6'h38;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef struct packed {
    iclass_t    iclass;
    logic [1:0] mask;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       jal;
    logic       lui;
    logic       zero_ext;
  } dec_t;

  // Classify an instruction and derive its datapath control fields.
  function automatic dec_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    d.mask = MASK_WORD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_JR: d.iclass = CL_JR;
          FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            d.iclass  = CL_ALU;
            d.reg_dst = 1'b1;
          end
          default: d.iclass = CL_NOP;
        endcase
      end
      OP_J:   d.iclass = CL_J;
      OP_JAL: begin d.iclass = CL_JAL; d.jal = 1'b1; end
      OP_BEQ: d.iclass = CL_BEQ;
      OP_BNE: d.iclass = CL_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.iclass = CL_ALU; d.alu_src = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.iclass = CL_ALU; d.alu_src = 1'b1; d.zero_ext = 1'b1;
      end
      OP_LUI: begin d.iclass = CL_ALU; d.alu_src = 1'b1; d.lui = 1'b1; end
      OP_LB, OP_LBU: begin
        d.iclass = CL_LOAD; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.mask = MASK_BYTE;
      end
      OP_LH, OP_LHU: begin
        d.iclass = CL_LOAD; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; d.mask = MASK_HALF;
      end
      OP_LW: begin d.iclass = CL_LOAD; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; end
      OP_SB: begin d.iclass = CL_STORE; d.alu_src = 1'b1; d.mask = MASK_BYTE; end
      OP_SH: begin d.iclass = CL_STORE; d.alu_src = 1'b1; d.mask = MASK_HALF; end
      OP_SW: begin d.iclass = CL_STORE; d.alu_src = 1'b1; end
      OP_LL: begin d.iclass = CL_LL; d.alu_src = 1'b1; d.mem_to_reg = 1'b1; end
      OP_SC: begin d.iclass = CL_SC; d.alu_src = 1'b1; end
      default: d.iclass = CL_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/llsc_reservation.sv
// Word-granular LL/SC reservation: valid bit plus reserved word address, snoop invalidation.
// Latency: set/clear take effect the cycle after; match is combinational on the stored state.
// Backpressure: none; set has priority over clear and snoop in the same cycle.
module llsc_reservation #(
  parameter int WORD_W  = 30,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [WORD_W-1:0] set_word,
  input  logic              clr,
  input  logic              snoop_wr,
  input  logic [WORD_W-1:0] snoop_word,
  input  logic [WORD_W-1:0] lookup_word,
  output logic              match
);

  if (LLSC_EN) begin : g_resv
    logic              valid_q;
    logic [WORD_W-1:0] word_q;

    // Reservation register: an LL completing in the same cycle as a snoop keeps its reservation.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        word_q  <= '0;
      end else if (set) begin
        valid_q <= 1'b1;
        word_q  <= set_word;
      end else if (clr || (snoop_wr && (snoop_word == word_q))) begin
        valid_q <= 1'b0;
      end
    end

    assign match = valid_q && (word_q == lookup_word);
  end else begin : g_tie
    logic unused_resv;
    assign unused_resv = ^{clk, rst, set, set_word, clr, snoop_wr, snoop_word, lookup_word};
    assign match = 1'b0;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM over a req/ready MMIO bus with LL/SC reservation and bus timeout trap.
// Latency: ALU 4, load 5, store 4, branch/jump 3 cycles, each plus bus wait cycles in FETCH/MEM.
// Backpressure: mem_req held until mem_ready_in; MEM_TIMEOUT stalled cycles trap into sticky ERROR.
module multicycle_control_unit
  import mmio_cpu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter bit LLSC_EN     = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       instruction_in,
  input  logic              alu_zero_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic              mem_ready_in,
  input  logic              snoop_wr_in,
  input  logic [ADDR_W-1:0] snoop_addr_in,
  output logic [2:0]        state_out,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mMask,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              jal,
  output logic              lui,
  output logic              zero_ext,
  output logic              sc_success,
  output logic              bus_error,
  output logic              instr_retired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  dec_t             dec_q;
  logic [CNT_W-1:0] tmo_q;
  logic             waiting, tmo_hit;
  logic             is_sc, sc_issue, sc_ok_q, sc_grant_q;
  logic             resv_match, resv_set, resv_clr;
  logic             unused_bits;

  assign unused_bits = ^{instruction_in[25:6], mem_addr_in[1:0], snoop_addr_in[1:0]};

  // An SC only goes to the bus with a live matching reservation; once issued it stays issued.
  assign is_sc    = (dec_q.iclass == CL_SC);
  assign sc_issue = is_sc && (!LLSC_EN || resv_match || sc_grant_q);
  assign resv_set = (state_q == MEM) && (dec_q.iclass == CL_LL) && mem_ready_in;
  assign resv_clr = (state_q == MEM) && is_sc && (!sc_issue || mem_ready_in);

  // Next-state and per-state strobes; strobes are forced low while reset is asserted.
  always_comb begin
    state_d       = state_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SEQ;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mMask         = MASK_BYTE;
    reg_write     = 1'b0;
    instr_retired = 1'b0;
    waiting       = 1'b0;
    tmo_hit       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        mMask   = MASK_WORD;
        if (mem_ready_in) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (dec_q.iclass)
          CL_BEQ: begin
            pc_write = alu_zero_in; pc_src = PC_BRANCH; instr_retired = 1'b1; state_d = FETCH;
          end
          CL_BNE: begin
            pc_write = !alu_zero_in; pc_src = PC_BRANCH; instr_retired = 1'b1; state_d = FETCH;
          end
          CL_J: begin
            pc_write = 1'b1; pc_src = PC_JUMP; instr_retired = 1'b1; state_d = FETCH;
          end
          CL_JAL: begin
            pc_write = 1'b1; pc_src = PC_JUMP; state_d = WB;
          end
          CL_JR: begin
            pc_write = 1'b1; pc_src = PC_REG; instr_retired = 1'b1; state_d = FETCH;
          end
          CL_LOAD, CL_STORE, CL_LL, CL_SC: state_d = MEM;
          CL_ALU: state_d = WB;
          default: begin instr_retired = 1'b1; state_d = FETCH; end
        endcase
      end
      MEM: begin
        if (is_sc && !sc_issue) begin
          state_d = WB;
        end else begin
          mem_req = 1'b1;
          mem_we  = (dec_q.iclass == CL_STORE) || is_sc;
          mMask   = dec_q.mask;
          if (mem_ready_in) begin
            if (dec_q.iclass == CL_STORE) begin
              instr_retired = 1'b1;
              state_d       = FETCH;
            end else begin
              state_d = WB;
            end
          end
        end
      end
      WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
      end
      ERROR: state_d = ERROR;
      default: state_d = FETCH;
    endcase
    waiting = mem_req && !mem_ready_in;
    tmo_hit = waiting && (tmo_q == CNT_W'(MEM_TIMEOUT - 1));
    if (tmo_hit) state_d = ERROR;
    if (rst_in) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = PC_SEQ;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mMask         = MASK_BYTE;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Decode fields are captured once per instruction and held until the next DECODE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                dec_q <= '0;
    else if (state_q == DECODE) dec_q <= decode_instr(instruction_in[31:26], instruction_in[5:0]);
  end

  // Stall counter: counts consecutive unanswered bus cycles, cleared whenever the bus is not stalled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                  tmo_q <= '0;
    else if (waiting && !tmo_hit) tmo_q <= tmo_q + 1'b1;
    else if (!waiting)           tmo_q <= '0;
  end

  // SC bookkeeping: outcome latched on leaving MEM, grant held across bus wait cycles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sc_ok_q    <= 1'b0;
      sc_grant_q <= 1'b0;
    end else begin
      if (resv_clr) sc_ok_q <= sc_issue;
      sc_grant_q <= (state_q == MEM) && sc_issue && !mem_ready_in;
    end
  end

  llsc_reservation #(
    .WORD_W  (ADDR_W - 2),
    .LLSC_EN (LLSC_EN)
  ) u_resv (
    .clk         (clk_in),
    .rst         (rst_in),
    .set         (resv_set),
    .set_word    (mem_addr_in[ADDR_W-1:2]),
    .clr         (resv_clr),
    .snoop_wr    (snoop_wr_in),
    .snoop_word  (snoop_addr_in[ADDR_W-1:2]),
    .lookup_word (mem_addr_in[ADDR_W-1:2]),
    .match       (resv_match)
  );

  assign state_out  = state_q;
  assign reg_dst    = dec_q.reg_dst;
  assign alu_src    = dec_q.alu_src;
  assign mem_to_reg = dec_q.mem_to_reg;
  assign jal        = dec_q.jal;
  assign lui        = dec_q.lui;
  assign zero_ext   = dec_q.zero_ext;
  assign sc_success = (state_q == WB) && is_sc && sc_ok_q;
  assign bus_error  = (state_q == ERROR);

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam logic [31:0] S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_ERROR = 5;
  localparam logic [31:0] I_ADDIU = 32'h24080001;
  localparam logic [31:0] I_LW    = 32'h8C090000;
  localparam logic [31:0] I_BEQ   = 32'h10000004;
  localparam logic [31:0] I_LL    = 32'hC0090000;
  localparam logic [31:0] I_SC    = 32'hE0090000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] instruction_in;
  logic        alu_zero_in;
  logic [31:0] mem_addr_in;
  logic        mem_ready_in;
  logic        snoop_wr_in;
  logic [31:0] snoop_addr_in;
  logic [2:0]  state_out;
  logic        ir_write, pc_write, mem_req, mem_we, reg_write;
  logic [1:0]  pc_src, mMask;
  logic        reg_dst, alu_src, mem_to_reg, jal, lui, zero_ext;
  logic        sc_success, bus_error, instr_retired;

  int passed = 0;
  int total  = 0;

  multicycle_control_unit #(.ADDR_W(32), .MEM_TIMEOUT(16), .LLSC_EN(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .instruction_in(instruction_in), .alu_zero_in(alu_zero_in),
    .mem_addr_in(mem_addr_in), .mem_ready_in(mem_ready_in), .snoop_wr_in(snoop_wr_in),
    .snoop_addr_in(snoop_addr_in), .state_out(state_out), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .mMask(mMask), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .jal(jal), .lui(lui),
    .zero_ext(zero_ext), .sc_success(sc_success), .bus_error(bus_error),
    .instr_retired(instr_retired)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Move to the next cycle: drive ready at the falling edge, sample 1 ns later.
  task automatic cyc(input logic rdy);
    @(negedge clk_in);
    mem_ready_in = rdy;
    #1;
  endtask

  initial begin
    rst_in = 1'b1; instruction_in = 32'h0; alu_zero_in = 1'b0; mem_addr_in = 32'h0;
    mem_ready_in = 1'b0; snoop_wr_in = 1'b0; snoop_addr_in = 32'h0;

    // Reset state: outputs low even with ready asserted.
    @(negedge clk_in); mem_ready_in = 1'b1; #1;
    chk("rst_state", state_out, S_FETCH);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_retired", instr_retired, 0);

    // ADDIU with immediate ready: FETCH, DECODE, EXEC, WB.
    instruction_in = I_ADDIU;
    @(negedge clk_in); rst_in = 1'b0; mem_ready_in = 1'b1; #1;
    chk("addiu_f_state", state_out, S_FETCH);
    chk("addiu_f_req", mem_req, 1);
    chk("addiu_f_mask", mMask, 2);
    chk("addiu_f_irw", ir_write, 1);
    chk("addiu_f_pcw", pc_write, 1);
    chk("addiu_f_pcsrc", pc_src, 0);
    chk("addiu_f_regw", reg_write, 0);
    cyc(1'b1);
    chk("addiu_d_state", state_out, S_DECODE);
    chk("addiu_d_req", mem_req, 0);
    chk("addiu_d_regw", reg_write, 0);
    chk("addiu_d_ret", instr_retired, 0);
    cyc(1'b1);
    chk("addiu_e_state", state_out, S_EXEC);
    chk("addiu_e_regw", reg_write, 0);
    chk("addiu_e_pcw", pc_write, 0);
    chk("addiu_e_ret", instr_retired, 0);
    instruction_in = I_LW;
    cyc(1'b1);
    chk("addiu_w_state", state_out, S_WB);
    chk("addiu_w_regw", reg_write, 1);
    chk("addiu_w_ret", instr_retired, 1);
    chk("addiu_alu_src", alu_src, 1);
    chk("addiu_reg_dst", reg_dst, 0);

    // LW with ready delayed three cycles in MEM.
    cyc(1'b1);
    chk("lw_f_state", state_out, S_FETCH);
    chk("lw_f_regw", reg_write, 0);
    chk("lw_f_ret", instr_retired, 0);
    cyc(1'b0);
    chk("lw_d_state", state_out, S_DECODE);
    cyc(1'b0);
    chk("lw_e_state", state_out, S_EXEC);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3);
      chk("lw_m_state", state_out, S_MEM);
      chk("lw_m_req", mem_req, 1);
      chk("lw_m_we", mem_we, 0);
      chk("lw_m_mask", mMask, 2);
      chk("lw_m_regw", reg_write, 0);
    end
    instruction_in = I_BEQ;
    cyc(1'b0);
    chk("lw_w_state", state_out, S_WB);
    chk("lw_w_regw", reg_write, 1);
    chk("lw_w_m2r", mem_to_reg, 1);
    chk("lw_w_ret", instr_retired, 1);

    // BEQ taken then not taken.
    cyc(1'b1);
    chk("beq1_f_state", state_out, S_FETCH);
    cyc(1'b0);
    alu_zero_in = 1'b1;
    cyc(1'b0);
    chk("beq1_e_state", state_out, S_EXEC);
    chk("beq1_e_pcw", pc_write, 1);
    chk("beq1_e_pcsrc", pc_src, 1);
    chk("beq1_e_ret", instr_retired, 1);
    cyc(1'b1);
    chk("beq2_f_state", state_out, S_FETCH);
    cyc(1'b0);
    alu_zero_in = 1'b0;
    cyc(1'b0);
    chk("beq2_e_pcw", pc_write, 0);
    chk("beq2_e_pcsrc", pc_src, 1);
    chk("beq2_e_ret", instr_retired, 1);

    // LL 0x100 then SC 0x100 succeeds.
    instruction_in = I_LL; mem_addr_in = 32'h100;
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    cyc(1'b1);
    chk("ll_m_state", state_out, S_MEM);
    chk("ll_m_req", mem_req, 1);
    chk("ll_m_we", mem_we, 0);
    instruction_in = I_SC;
    cyc(1'b0);
    chk("ll_w_regw", reg_write, 1);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    cyc(1'b1);
    chk("sc1_m_req", mem_req, 1);
    chk("sc1_m_we", mem_we, 1);
    instruction_in = I_LL;
    cyc(1'b0);
    chk("sc1_w_state", state_out, S_WB);
    chk("sc1_w_success", sc_success, 1);
    chk("sc1_w_regw", reg_write, 1);

    // LL 0x100, snoop write to 0x102 (same word), SC fails without a bus request.
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    instruction_in = I_SC;
    cyc(1'b0);
    chk("ll2_w_success", sc_success, 0);
    cyc(1'b1);
    cyc(1'b0);
    snoop_wr_in = 1'b1; snoop_addr_in = 32'h102;
    cyc(1'b0);
    snoop_wr_in = 1'b0;
    cyc(1'b1);
    chk("sc2_m_state", state_out, S_MEM);
    chk("sc2_m_req", mem_req, 0);
    chk("sc2_m_we", mem_we, 0);
    instruction_in = I_ADDIU;
    cyc(1'b0);
    chk("sc2_w_state", state_out, S_WB);
    chk("sc2_w_success", sc_success, 0);
    chk("sc2_w_regw", reg_write, 1);
    chk("sc2_w_ret", instr_retired, 1);

    // Fetch stalled: 16 waiting cycles, then sticky ERROR.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0);
      chk("tmo_wait_state", state_out, S_FETCH);
      chk("tmo_wait_berr", bus_error, 0);
    end
    cyc(1'b0);
    chk("tmo_err_state", state_out, S_ERROR);
    chk("tmo_err_berr", bus_error, 1);
    chk("tmo_err_req", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("tmo_sticky_state", state_out, S_ERROR);
      chk("tmo_sticky_berr", bus_error, 1);
      chk("tmo_sticky_irw", ir_write, 0);
    end

    // Reset clears ERROR; then reset asserted mid-MEM drops mem_req immediately.
    @(negedge clk_in); rst_in = 1'b1; #1;
    chk("err_rst_state", state_out, S_FETCH);
    chk("err_rst_berr", bus_error, 0);
    instruction_in = I_LW;
    @(negedge clk_in); rst_in = 1'b0; mem_ready_in = 1'b1; #1;
    chk("rst2_f_irw", ir_write, 1);
    cyc(1'b0); cyc(1'b0);
    cyc(1'b0);
    chk("mid_m_state", state_out, S_MEM);
    chk("mid_m_req", mem_req, 1);
    #2; rst_in = 1'b1; #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_state", state_out, S_FETCH);
    chk("mid_rst_ret", instr_retired, 0);
    @(negedge clk_in); rst_in = 1'b0; mem_ready_in = 1'b1; #1;
    chk("restart_state", state_out, S_FETCH);
    chk("restart_req", mem_req, 1);
    chk("restart_irw", ir_write, 1);
    cyc(1'b0);
    chk("restart_d_state", state_out, S_DECODE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
